unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Sequencer and arbiter that shares one single-port unified memory between the pipeline's instruction-fetch stage and its data-memory (lw/sw) stage. It serialises the two requesters onto a variable-latency req/ready memory port and returns per-requester done pulses and stall levels to the pipeline controller. It lets the pipelined core run against a single memory instead of split instruction and data memories. Flushed fetches in flight are discarded safely.

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done or if_cancel
- if_addr  in  ADDR_W  fetch address, stable while if_req is high
- if_cancel  in  1  one-cycle flush pulse (IF_flush); aborts the current fetch
- if_rdata  out  DATA_W  fetched word, registered
- if_done  out  1  one-cycle pulse; if_rdata is valid
- if_stall  out  1  if_req & ~if_done
- dm_read  in  1  data read request, level
- dm_write  in  1  data write request, level
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_done  out  1  one-cycle pulse; access complete
- dm_stall  out  1  (dm_read|dm_write) & ~dm_done
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  one-cycle completion strobe from memory

## Operation
- FSM states: IDLE, FETCH, DATA, RESP_IF, RESP_DM. A discard flag and a last_grant bit (IF/DM) are also kept.
- IDLE behaviour:
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the one not equal to last_grant.
  - On a grant, latch mem_addr, mem_wdata and mem_we, update last_grant, and move to FETCH or DATA.
- FETCH/DATA:
  - mem_req=1; address, data and we are held stable.
  - On an edge with mem_ready=1, capture mem_rdata and move to RESP_IF or RESP_DM.
  - A DATA write does not update dm_rdata.
- RESP_IF / RESP_DM: assert the matching done for one cycle, then go to IDLE. The requester drops or changes its request on that same edge.
- Cancel handling:
  - if_cancel in IDLE: no effect.
  - if_cancel in FETCH: set discard. The memory transaction still completes because it cannot be aborted. On mem_ready, go to IDLE with no if_done and leave if_rdata unchanged. Clear discard.
  - if_cancel in RESP_IF: suppress if_done that cycle.
- dm_read and dm_write both high is illegal. It is treated as a write and flagged by a bench assertion.
- The stall outputs are combinational from the request inputs and done.

## Timing
- Reset is asynchronous. All of the following clear immediately: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, discard=0, last_grant=IF (so the first tie goes to DM).
- Reset mid-transaction drops mem_req at once, and the memory must tolerate an abandoned request. After reset release, the first grant occurs on the first edge in IDLE.
- Per-access timing, with the request first seen in IDLE at cycle 0:
  - Cycle 1: mem_req=1.
  - mem_ready arrives at cycle k≥1.
  - Cycle k+1: done=1.
  - Cycle k+2: back in IDLE.
- Minimum latency is 2 cycles from request to done. Back-to-back throughput is 1 access per 3 cycles minimum.
- mem_ready outside FETCH/DATA is ignored.
- mem_ready and if_cancel in the same FETCH cycle: discard takes effect and no if_done is produced.
- At most one of if_done or dm_done is high in any cycle.

## Test plan
- Lone fetch: if_req=1, if_addr=0x40, mem_ready on cycle 1 with mem_rdata=0x8C010004 -> mem_req high only in cycle 1, if_done in cycle 2, if_rdata=0x8C010004, if_stall low in cycle 2.
- Tie alternation: if_req and dm_read held high from reset -> grant order DM, IF, DM, IF. The bench checks mem_addr and last_grant each grant.
- Store: dm_write=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=0xDEADBEEF held for 4 cycles, one dm_done pulse, dm_rdata unchanged.
- Flush during fetch: if_cancel in cycle 2 of a 4-cycle fetch -> mem_req holds until mem_ready, no if_done, if_rdata unchanged. A new if_addr=0x200 request is then granted from IDLE.
- Async reset mid DATA: rst low between edges -> mem_req, mem_we and done drop immediately. After release, the next tie goes to DM.
- Random wait 1–8 cycles for 1000 mixed accesses -> each request gets exactly one done, with data matching a memory model and no overlapping mem_req transactions.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port req/ready memory between the fetch stage and the lw/sw stage.
// Round-robin on ties, one access in flight, flushed fetches are drained and discarded.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, RESP_IF, RESP_DM} state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  state_e             state_q, state_d;
  logic               discard_q, discard_d;
  logic               last_grant_q, last_grant_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
  logic               dm_pend, grant_dm, grant_if;

  assign dm_pend  = dm_read | dm_write;
  // On a tie the requester that did not win last time goes first.
  assign grant_dm = dm_pend & (~if_req | (last_grant_q == GNT_IF));
  assign grant_if = if_req & ~grant_dm;

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    last_grant_d = last_grant_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          mem_we_d     = dm_write;
          last_grant_d = GNT_DM;
          state_d      = DATA;
        end else if (grant_if) begin
          mem_addr_d   = if_addr;
          mem_we_d     = 1'b0;
          last_grant_d = GNT_IF;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (if_cancel) discard_d = 1'b1;
        // The memory cannot abort, so a flushed fetch still waits for ready.
        if (mem_ready) begin
          discard_d = 1'b0;
          if (discard_q | if_cancel) begin
            state_d = IDLE;
          end else begin
            if_rdata_d = mem_rdata;
            state_d    = RESP_IF;
          end
        end
      end
      DATA: begin
        if (mem_ready) begin
          if (!mem_we_q) dm_rdata_d = mem_rdata;
          mem_we_d = 1'b0;
          state_d  = RESP_DM;
        end
      end
      RESP_IF: state_d = IDLE;
      RESP_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      last_grant_q <= GNT_IF;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_req   = (state_q == FETCH) | (state_q == DATA);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = (state_q == RESP_IF) & ~if_cancel;
  assign dm_done   = (state_q == RESP_DM);
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_pend & ~dm_done;

endmodule
